// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one port of the 128x512 tile SRAM between the
// DMA/fill requester (req0) and the Winograd PE requester (req1). It
// arbitrates round-robin, registers the SRAM control and data pins, tags read
// responses with the requester id, and can zero the whole array between layers.
module sram_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 512,
  parameter int DEPTH  = 128   // must equal 2**ADDR_W so the clear covers every word
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

  logic [1:0]        r_state;
  logic              r_rrPtr;
  logic [ADDR_W-1:0] r_clrCnt;
  logic              r_csb;
  logic              r_web;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_issueId;
  logic              r_rspValid;
  logic              r_rspId;

  logic              w_serve;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic              w_winner;
  logic              w_selWe;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selWdata;
  logic              w_clrLast;
  logic              w_readIssued;

  // Round-robin grant: a lone requester always wins, on contention rr_ptr picks.
  always_comb begin
    w_serve    = (r_state == SERVE);
    w_grant0   = w_serve & req0_valid & (~req1_valid | ~r_rrPtr);
    w_grant1   = w_serve & req1_valid & (~req0_valid |  r_rrPtr);
    w_accept   = w_grant0 | w_grant1;
    w_winner   = w_grant1;
    w_selWe    = w_winner ? req1_we    : req0_we;
    w_selAddr  = w_winner ? req1_addr  : req0_addr;
    w_selWdata = w_winner ? req1_wdata : req0_wdata;
    w_clrLast  = (r_clrCnt == CLR_LAST);
    // The SRAM samples the registered pins at the next edge; a read there
    // means data appears on sram_o in the following cycle.
    w_readIssued = ~r_csb & r_web;
  end

  // Top-level state and clear counter; the counter only wraps when CLEAR exits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_clrCnt <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= SERVE;
        SERVE: begin
          if (clr_start) begin
            r_state  <= CLEAR;
            r_clrCnt <= '0;
          end
        end
        CLEAR: begin
          if (w_clrLast) begin
            r_state  <= SERVE;
            r_clrCnt <= '0;
          end else begin
            r_clrCnt <= r_clrCnt + CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Round-robin pointer moves away from whoever was just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= 1'b0;
    end else if (w_accept) begin
      r_rrPtr <= ~w_winner;
    end
  end

  // SRAM pin registers: clear writes, accepted accesses, or deselect and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csb     <= 1'b1;
      r_web     <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_issueId <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_csb   <= 1'b0;
      r_web   <= 1'b0;
      r_addr  <= r_clrCnt;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_csb     <= 1'b0;
      r_web     <= ~w_selWe;
      r_addr    <= w_selAddr;
      r_wdata   <= w_selWdata;
      r_issueId <= w_winner;
    end else begin
      r_csb <= 1'b1;
    end
  end

  // Response tag lines up with the cycle in which sram_o carries the read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= 1'b0;
      r_rspId    <= 1'b0;
    end else begin
      r_rspValid <= w_readIssued;
      if (w_readIssued) begin
        r_rspId <= r_issueId;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign clr_busy   = (r_state == CLEAR);
  assign rsp_valid  = r_rspValid;
  assign rsp_id     = r_rspId;
  assign rsp_data   = sram_o;
  assign sram_csb   = r_csb;
  assign sram_web   = r_web;
  assign sram_oeb   = 1'b0;
  assign sram_a     = r_addr;
  assign sram_i     = r_wdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed tests for the SRAM port arbiter with a small
// behavioural model of the clocked SRAM attached to the controlled port.
module tb_sram_port_arbiter;

  logic         clk;
  logic         rst_n;
  logic         clr_start;
  logic         clr_busy;
  logic         req0_valid, req0_ready, req0_we;
  logic [6:0]   req0_addr;
  logic [511:0] req0_wdata;
  logic         req1_valid, req1_ready, req1_we;
  logic [6:0]   req1_addr;
  logic [511:0] req1_wdata;
  logic         rsp_valid, rsp_id;
  logic [511:0] rsp_data;
  logic         sram_csb, sram_web, sram_oeb;
  logic [6:0]   sram_a;
  logic [511:0] sram_i, sram_o;

  logic [511:0] mem [0:127];
  logic [511:0] memDout;

  int checks = 0;
  int errors = 0;

  logic         obsValid, obsId;
  logic [511:0] obsData;

  sram_port_arbiter #(.ADDR_W(7), .DATA_W(512), .DEPTH(128)) dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM port: CE is clk, registered read data.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else           memDout     <= mem[sram_a];
    end
  end
  assign sram_o = memDout;

  task automatic doAccess(input bit id, input bit we, input logic [6:0] addr, input logic [511:0] data);
    int guard;
    guard = 0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = data;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = data;
    end
    #1;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && guard < 400) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("[TB] FAIL access_timeout: ready=%b after %0d cycles, required 1", id ? req1_ready : req0_ready, guard);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic readWord(input bit id, input logic [6:0] addr);
    doAccess(id, 1'b0, addr, '0);
    @(negedge clk);
    @(negedge clk);
    obsValid = rsp_valid;
    obsId    = rsp_id;
    obsData  = rsp_data;
  endtask

  task automatic fillWords(input bit ones);
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req0_we    = 1'b1;
      req0_addr  = 7'(k);
      req0_wdata = ones ? {512{1'b1}} : {64{8'(k)}};
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_start = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    #12;
    checks++;
    if ({sram_csb, sram_web, sram_oeb} !== 3'b110) begin
      errors++; $display("[TB] FAIL reset_ctrl: csb/web/oeb=%b required 110", {sram_csb, sram_web, sram_oeb});
    end
    checks++;
    if ({clr_busy, req0_ready, req1_ready, rsp_valid, rsp_id} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags: busy/rdy0/rdy1/rspv/rspid=%b required 00000",
                         {clr_busy, req0_ready, req1_ready, rsp_valid, rsp_id});
    end
    checks++;
    if (sram_a !== 7'd0 || sram_i !== 512'd0) begin
      errors++; $display("[TB] FAIL reset_addr_data: a=%0d i_nonzero=%b required 0", sram_a, |sram_i);
    end
  endtask

  task automatic test_contention();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 7'd10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 7'd20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_no_ready: rdy0=%b rdy1=%b required 0 0", req0_ready, req1_ready);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      #1;
      if (i < 4) begin
        checks++;
        if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
          errors++; $display("[TB] FAIL contention_grant%0d: rdy0=%b rdy1=%b required %b %b",
                             i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
        end
      end
      if (i >= 2 && i < 6) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'((i - 2) % 2)) begin
          errors++; $display("[TB] FAIL contention_rsp%0d: valid=%b id=%b required 1 %0d",
                             i - 2, rsp_valid, rsp_id, (i - 2) % 2);
        end
      end
      if (i == 6) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL contention_rsp_end: valid=%b required 0", rsp_valid);
        end
      end
    end
  endtask

  task automatic test_write_read();
    doAccess(1'b0, 1'b1, 7'd5, {64{8'hA5}});
    doAccess(1'b0, 1'b0, 7'd5, '0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL wr_rd_early: valid=%b required 0 one cycle after accept", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== {64{8'hA5}}) begin
      errors++; $display("[TB] FAIL wr_rd_rsp: valid=%b id=%b data=%h required 1 0 a5..a5", rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || sram_oeb !== 1'b0) begin
      errors++; $display("[TB] FAIL wr_rd_pulse: valid=%b oeb=%b required 0 0", rsp_valid, sram_oeb);
    end
  endtask

  task automatic test_streaming();
    fillWords(1'b0);
    for (int k = 0; k < 131; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (k >= 2 && k < 130) begin
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== {64{8'(k - 2)}}) begin
          errors++; $display("[TB] FAIL stream_rsp%0d: valid=%b id=%b data=%h required 1 1 %h",
                             k - 2, rsp_valid, rsp_id, rsp_data, {64{8'(k - 2)}});
        end
      end else if (rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL stream_idle%0d: valid=%b required 0", k, rsp_valid);
      end
      if (k < 128) begin
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 7'(k);
      end else begin
        req1_valid = 1'b0;
      end
    end
  endtask

  task automatic test_clear();
    int badCycles;
    fillWords(1'b1);
    @(negedge clk);
    clr_start = 1'b1;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_busy_before: busy=%b required 0", clr_busy);
    end
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 7'd1;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 7'd2;
    badCycles = 0;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      if (clr_busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) badCycles++;
      if (j == 10) begin
        checks++;
        if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_a !== 7'd9 || sram_i !== 512'd0) begin
          errors++; $display("[TB] FAIL clear_pins: csb=%b web=%b a=%0d i_nonzero=%b required 0 0 9 0",
                             sram_csb, sram_web, sram_a, |sram_i);
        end
      end
    end
    checks++;
    if (badCycles !== 0) begin
      errors++; $display("[TB] FAIL clear_busy_window: %0d bad cycles, required 0", badCycles);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_busy_after: busy=%b required 0", clr_busy);
    end
    readWord(1'b0, 7'd0);
    checks++;
    if (obsValid !== 1'b1 || obsData !== 512'd0) begin
      errors++; $display("[TB] FAIL clear_word0: valid=%b data=%h required 1 0", obsValid, obsData);
    end
    readWord(1'b1, 7'd64);
    checks++;
    if (obsValid !== 1'b1 || obsId !== 1'b1 || obsData !== 512'd0) begin
      errors++; $display("[TB] FAIL clear_word64: valid=%b id=%b data=%h required 1 1 0", obsValid, obsId, obsData);
    end
    readWord(1'b0, 7'd127);
    checks++;
    if (obsValid !== 1'b1 || obsData !== 512'd0) begin
      errors++; $display("[TB] FAIL clear_word127: valid=%b data=%h required 1 0", obsValid, obsData);
    end
  endtask

  task automatic test_simultaneous();
    int guard;
    doAccess(1'b0, 1'b1, 7'd9, {64{8'h5A}});
    @(negedge clk);
    clr_start = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 7'd9;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL simul_ready: rdy0=%b required 1", req0_ready);
    end
    @(posedge clk);
    #1;
    clr_start = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (clr_busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_busy: busy=%b rspv=%b required 1 0", clr_busy, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== {64{8'h5A}}) begin
      errors++; $display("[TB] FAIL simul_rsp: valid=%b id=%b data=%h required 1 0 5a..5a", rsp_valid, rsp_id, rsp_data);
    end
    guard = 0;
    while (clr_busy === 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      errors++; $display("[TB] FAIL simul_clear_timeout: busy=%b required 0", clr_busy);
    end
    readWord(1'b0, 7'd9);
    checks++;
    if (obsValid !== 1'b1 || obsData !== 512'd0) begin
      errors++; $display("[TB] FAIL simul_cleared9: valid=%b data=%h required 1 0", obsValid, obsData);
    end
  endtask

  task automatic test_reset_mid_clear();
    fillWords(1'b1);
    @(negedge clk);
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    for (int j = 0; j <= 40; j++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sram_csb !== 1'b1 || clr_busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midclr_reset: csb=%b busy=%b rspv=%b required 1 0 0", sram_csb, clr_busy, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    readWord(1'b0, 7'd0);
    checks++;
    if (obsData !== 512'd0) begin
      errors++; $display("[TB] FAIL midclr_word0: data=%h required 0", obsData);
    end
    readWord(1'b0, 7'd38);
    checks++;
    if (obsData !== 512'd0) begin
      errors++; $display("[TB] FAIL midclr_word38: data=%h required 0", obsData);
    end
    readWord(1'b1, 7'd40);
    checks++;
    if (obsValid !== 1'b1 || obsData !== {512{1'b1}}) begin
      errors++; $display("[TB] FAIL midclr_word40: valid=%b data=%h required 1 ff..ff", obsValid, obsData);
    end
    readWord(1'b0, 7'd127);
    checks++;
    if (obsData !== {512{1'b1}}) begin
      errors++; $display("[TB] FAIL midclr_word127: data=%h required ff..ff", obsData);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_write_read();
    test_streaming();
    test_clear();
    test_simultaneous();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
